zap_cp15_ctrl: RTL and testbench
================================

Name: zap_cp15_ctrl

Overview:
- System-control coprocessor (CP15) on the consumer side of the coprocessor-predecode handshake.
- Accepts the registered coprocessor request: dav, instruction word, translated physical register index and CPSR.
- Executes MRC/MCR against a small CP15 register bank, using a dedicated CPU register-file port, then returns a done indication that releases the decode stall.
- Drives MMU/cache enables, TTB and DAC to the memory subsystem, and issues cache/TLB maintenance requests.

Parameters:
PHY_REGS, 46, number of physical CPU registers; index width is clog2(PHY_REGS).
CP_NUM, 15, coprocessor number this block answers to.
ID_CODE, 32'h4107_B000, value returned for c0 reads.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_dav  in  1  coprocessor request valid; held high until done is consumed
i_cp_word  in  32  full coprocessor instruction
i_cp_reg  in  clog2(PHY_REGS)  translated physical index of Rd
i_cpsr  in  32  CPSR at time of request
o_done  out  1  request complete
o_undef  out  1  one-cycle pulse with first done cycle: instruction rejected
o_reg_en  out  1  register-file read strobe
o_reg_rd_ndx  out  clog2(PHY_REGS)  read index
i_reg_rd_data  in  32  read data, valid the cycle after o_reg_en
o_reg_wr_en  out  1  register-file write strobe
o_reg_wr_ndx  out  clog2(PHY_REGS)  write index
o_reg_wr_data  out  32  write data
o_mmu_en, o_dcache_en, o_icache_en  out  1 each  c1 bits 0, 2, 12
o_baddr  out  18  c2[31:14] translation table base
o_dac  out  32  c3 domain access control
i_fault_valid  in  1  abort capture strobe
i_fsr  in  8  fault status
i_far  in  32  fault address
o_cache_inv  out  2  {I, D} invalidate request
i_cache_inv_done  in  1  cache maintenance complete
o_tlb_inv  out  1  TLB invalidate request
i_tlb_inv_done  in  1  TLB maintenance complete

Behaviour:
- Reset: i_reset is synchronous, active-high, sampled on i_clk; state IDLE; all outputs 0; c1, c2, c3, c5, c6 cleared. Reset mid-operation aborts immediately with no register-file write.
- Decode fields:
  - L = word[20] (1 = MRC), CRn = [19:16], CP# = [11:8], opc2 = [7:5], CRm = [3:0].
  - Legal request: [27:24] = 4'b1110, [4] = 1, CP# = CP_NUM, CPSR mode not USR (5'b10000).
- States: IDLE, RD_REQ, RD_WAIT, WR, MAINT, DONE.
- IDLE:
  - i_dav = 1 and illegal (LDC/STC/CDP, wrong CP#, user mode) -> DONE with o_undef.
  - Legal MCR -> RD_REQ.
  - Legal MRC -> WR.
- RD_REQ: o_reg_en = 1, o_reg_rd_ndx = i_cp_reg -> RD_WAIT.
- RD_WAIT:
  - Capture i_reg_rd_data into CRn.
  - Writable fields: c1 bits 0/2/12 (others read 0), c2[31:14], c3, c5[7:0], c6.
  - c0 and unimplemented CRn: writes ignored.
  - CRn = 7 -> MAINT with o_cache_inv = {CRm==5|CRm==7, CRm==6|CRm==7}; if that is 0, go to DONE instead.
  - CRn = 8 -> MAINT with o_tlb_inv = 1.
  - Otherwise -> DONE.
- MAINT: requests held until the matching done input is seen high; then clear requests -> DONE. No timeout.
- WR:
  - o_reg_wr_en = 1, o_reg_wr_ndx = i_cp_reg, o_reg_wr_data = CP15 value of CRn (c0 = ID_CODE; c7/c8/unimplemented = 0) -> DONE.
  - If Rd field = 15, the write is suppressed; completion proceeds normally.
- DONE:
  - o_done = 1 (Moore).
  - Held while i_dav = 1, to tolerate upstream stalls; i_dav = 0 -> IDLE.
  - o_undef pulses only on the first DONE cycle.
- Latency from i_dav first high in IDLE to o_done: MRC 2 cycles, plain MCR 3 cycles, illegal 1 cycle.
- Fault capture:
  - i_fault_valid loads c5 <= i_fsr and c6 <= i_far in any state.
  - If an MCR to c5/c6 lands in the same cycle, the fault wins.
- Outputs o_mmu_en..o_dac are direct register outputs, updated the cycle after the RD_WAIT write.

Test Plan:
- MCR p15,0,r0,c1,c0,0 with r0 = 32'h0000_1005, SVC mode -> o_reg_en in cycle 1; o_done in cycle 3; o_mmu_en = o_dcache_en = o_icache_en = 1; MRC back returns 32'h0000_1005.
- MRC p15,0,r3,c0,c0,0 -> o_reg_wr_en in cycle 1, index = i_cp_reg, data = 32'h4107_B000; o_done in cycle 2.
- MCR to c7 with CRm = 7 -> o_cache_inv = 2'b11 held; i_cache_inv_done after 5 cycles -> requests drop; o_done the next cycle. Repeat for c8 using o_tlb_inv and i_tlb_inv_done.
- MCR from user mode (CPSR[4:0] = 5'b10000), and CP# = 14 -> o_done plus o_undef one cycle after dav; no register-file access; c1 unchanged.
- i_dav held 4 cycles after done -> o_done stays 1 throughout; single undef pulse; returns to IDLE when dav drops; no second execution.
- Simultaneous i_fault_valid (FSR = 8'h05, FAR = 32'hDEAD_BEEF) with MCR c6 = 0 -> c6 reads 32'hDEAD_BEEF. Reset asserted during MAINT -> all requests and enables 0 next cycle.

Source files
------------

// File: rtl/zap_cp15_ctrl_if.sv
// Coprocessor request bundle between the predecode stage (master) and the
// CP15 controller (slave).
//
// Handshake: the master raises i_dav together with a stable i_cp_word,
// i_cp_reg and i_cpsr, and keeps all four constant until it has seen o_done.
// The slave raises o_done once the request has fully executed and holds it
// for as long as i_dav stays high. Dropping i_dav while o_done is high ends
// the transaction. o_undef is valid only on the first o_done cycle.
interface zap_cp15_ctrl_if #(
  parameter int PHY_REGS = 46
);
  logic                        i_dav;
  logic [31:0]                 i_cp_word;
  logic [$clog2(PHY_REGS)-1:0] i_cp_reg;
  logic [31:0]                 i_cpsr;
  logic                        o_done;
  logic                        o_undef;

  modport master (
    output i_dav, i_cp_word, i_cp_reg, i_cpsr,
    input  o_done, o_undef
  );

  modport slave (
    input  i_dav, i_cp_word, i_cp_reg, i_cpsr,
    output o_done, o_undef
  );
endinterface

// File: rtl/zap_cp15_ctrl.sv
// CP15 system-control coprocessor. Executes MRC/MCR against a small register
// bank (c0 ID, c1 control, c2 TTB, c3 DAC, c5 FSR, c6 FAR), uses a private
// register-file port for Rd, and issues cache/TLB maintenance for c7/c8.
module zap_cp15_ctrl #(
  parameter int          PHY_REGS = 46,
  parameter int          CP_NUM   = 15,
  parameter logic [31:0] ID_CODE  = 32'h4107_B000
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  zap_cp15_ctrl_if.slave              cp_bus,
  output logic                        o_reg_en,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_rd_ndx,
  input  logic [31:0]                 i_reg_rd_data,
  output logic                        o_reg_wr_en,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_wr_ndx,
  output logic [31:0]                 o_reg_wr_data,
  output logic                        o_mmu_en,
  output logic                        o_dcache_en,
  output logic                        o_icache_en,
  output logic [17:0]                 o_baddr,
  output logic [31:0]                 o_dac,
  input  logic                        i_fault_valid,
  input  logic [7:0]                  i_fsr,
  input  logic [31:0]                 i_far,
  output logic [1:0]                  o_cache_inv,
  input  logic                        i_cache_inv_done,
  output logic                        o_tlb_inv,
  input  logic                        i_tlb_inv_done,
  output logic [2:0]                  o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_MAINT   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                        r_state;
  logic                          r_undef;
  logic                          r_reg_en;
  logic [$clog2(PHY_REGS)-1:0]   r_rd_ndx;
  logic                          r_wr_en;
  logic [$clog2(PHY_REGS)-1:0]   r_wr_ndx;
  logic [31:0]                   r_wr_data;
  logic                          r_c1_m;
  logic                          r_c1_d;
  logic                          r_c1_i;
  logic [17:0]                   r_c2;
  logic [31:0]                   r_c3;
  logic [7:0]                    r_c5;
  logic [31:0]                   r_c6;
  logic [1:0]                    r_cache_inv;
  logic                          r_tlb_inv;

  logic                          w_is_mrc;
  logic [3:0]                    w_crn;
  logic [3:0]                    w_rd;
  logic [3:0]                    w_cpn;
  logic [3:0]                    w_crm;
  logic                          w_legal;
  logic [31:0]                   w_rd_val;
  logic [1:0]                    w_cinv;
  logic                          w_maint_ack;
  logic                          w_unused;

  // Field decode, legality check and CP15 read mux for the pending request.
  always_comb begin
    w_is_mrc = cp_bus.i_cp_word[20];
    w_crn    = cp_bus.i_cp_word[19:16];
    w_rd     = cp_bus.i_cp_word[15:12];
    w_cpn    = cp_bus.i_cp_word[11:8];
    w_crm    = cp_bus.i_cp_word[3:0];
    // Only register transfers (MRC/MCR) to our CP number from a privileged
    // mode are accepted; LDC/STC/CDP fail the [27:24]/[4] test.
    w_legal  = (cp_bus.i_cp_word[27:24] == 4'b1110) &&
               cp_bus.i_cp_word[4] &&
               (w_cpn == 4'(CP_NUM)) &&
               (cp_bus.i_cpsr[4:0] != 5'b10000);
    w_rd_val = 32'd0;
    case (w_crn)
      4'd0:    w_rd_val = ID_CODE;
      4'd1:    w_rd_val = {19'd0, r_c1_i, 9'd0, r_c1_d, 1'b0, r_c1_m};
      4'd2:    w_rd_val = {r_c2, 14'd0};
      4'd3:    w_rd_val = r_c3;
      4'd5:    w_rd_val = {24'd0, r_c5};
      4'd6:    w_rd_val = r_c6;
      default: w_rd_val = 32'd0;
    endcase
    // {I, D}: CRm 5 = I only, 6 = D only, 7 = both.
    w_cinv      = {(w_crm == 4'd5) || (w_crm == 4'd7),
                   (w_crm == 4'd6) || (w_crm == 4'd7)};
    // Only the done input matching the outstanding request releases MAINT.
    w_maint_ack = r_tlb_inv ? i_tlb_inv_done : i_cache_inv_done;
  end

  // Request FSM, CP15 register bank and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_undef     <= 1'b0;
      r_reg_en    <= 1'b0;
      r_rd_ndx    <= '0;
      r_wr_en     <= 1'b0;
      r_wr_ndx    <= '0;
      r_wr_data   <= 32'd0;
      r_c1_m      <= 1'b0;
      r_c1_d      <= 1'b0;
      r_c1_i      <= 1'b0;
      r_c2        <= 18'd0;
      r_c3        <= 32'd0;
      r_c5        <= 8'd0;
      r_c6        <= 32'd0;
      r_cache_inv <= 2'b00;
      r_tlb_inv   <= 1'b0;
    end else begin
      // Strobes and the undef pulse last exactly one cycle.
      r_undef  <= 1'b0;
      r_reg_en <= 1'b0;
      r_wr_en  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (cp_bus.i_dav) begin
            if (!w_legal) begin
              r_state <= S_DONE;
              r_undef <= 1'b1;
            end else if (w_is_mrc) begin
              r_state   <= S_WR;
              // Rd = PC is not a legal MRC destination here; drop the write.
              r_wr_en   <= (w_rd != 4'd15);
              r_wr_ndx  <= cp_bus.i_cp_reg;
              r_wr_data <= w_rd_val;
            end else begin
              r_state  <= S_RD_REQ;
              r_reg_en <= 1'b1;
              r_rd_ndx <= cp_bus.i_cp_reg;
            end
          end
        end

        S_RD_REQ: begin
          r_state <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          r_state <= S_DONE;
          case (w_crn)
            4'd1: begin
              r_c1_m <= i_reg_rd_data[0];
              r_c1_d <= i_reg_rd_data[2];
              r_c1_i <= i_reg_rd_data[12];
            end
            4'd2: r_c2 <= i_reg_rd_data[31:14];
            4'd3: r_c3 <= i_reg_rd_data;
            4'd5: r_c5 <= i_reg_rd_data[7:0];
            4'd6: r_c6 <= i_reg_rd_data;
            4'd7: begin
              if (w_cinv != 2'b00) begin
                r_cache_inv <= w_cinv;
                r_state     <= S_MAINT;
              end
            end
            4'd8: begin
              r_tlb_inv <= 1'b1;
              r_state   <= S_MAINT;
            end
            default: ;
          endcase
        end

        S_WR: begin
          r_state <= S_DONE;
        end

        S_MAINT: begin
          if (w_maint_ack) begin
            r_cache_inv <= 2'b00;
            r_tlb_inv   <= 1'b0;
            r_state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (!cp_bus.i_dav) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // Abort capture sits after the FSM so it overrides a same-cycle MCR.
      if (i_fault_valid) begin
        r_c5 <= i_fsr;
        r_c6 <= i_far;
      end
    end
  end

  assign cp_bus.o_done   = (r_state == S_DONE);
  assign cp_bus.o_undef  = r_undef;
  assign o_reg_en        = r_reg_en;
  assign o_reg_rd_ndx    = r_rd_ndx;
  assign o_reg_wr_en     = r_wr_en;
  assign o_reg_wr_ndx    = r_wr_ndx;
  assign o_reg_wr_data   = r_wr_data;
  assign o_mmu_en        = r_c1_m;
  assign o_dcache_en     = r_c1_d;
  assign o_icache_en     = r_c1_i;
  assign o_baddr         = r_c2;
  assign o_dac           = r_c3;
  assign o_cache_inv     = r_cache_inv;
  assign o_tlb_inv       = r_tlb_inv;
  assign o_state         = r_state;

  // Instruction and CPSR bits this block does not decode.
  assign w_unused = &{1'b0, cp_bus.i_cpsr[31:5], cp_bus.i_cp_word[31:28],
                      cp_bus.i_cp_word[23:21], cp_bus.i_cp_word[7:5]};

endmodule

// File: tb/tb_zap_cp15_ctrl.sv
// Directed testbench for zap_cp15_ctrl: MCR/MRC timing, register bank
// contents, maintenance handshakes, illegal requests, fault capture, reset.
module tb_zap_cp15_ctrl;

  localparam logic [31:0] SVC     = 32'h0000_00D3;
  localparam logic [31:0] USR     = 32'h0000_0010;
  localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  zap_cp15_ctrl_if #(.PHY_REGS(46)) cp_bus ();

  logic        o_reg_en;
  logic [5:0]  o_reg_rd_ndx;
  logic [31:0] i_reg_rd_data;
  logic        o_reg_wr_en;
  logic [5:0]  o_reg_wr_ndx;
  logic [31:0] o_reg_wr_data;
  logic        o_mmu_en, o_dcache_en, o_icache_en;
  logic [17:0] o_baddr;
  logic [31:0] o_dac;
  logic        i_fault_valid;
  logic [7:0]  i_fsr;
  logic [31:0] i_far;
  logic [1:0]  o_cache_inv;
  logic        i_cache_inv_done;
  logic        o_tlb_inv;
  logic        i_tlb_inv_done;
  logic [2:0]  o_state;

  zap_cp15_ctrl dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .cp_bus           (cp_bus),
    .o_reg_en         (o_reg_en),
    .o_reg_rd_ndx     (o_reg_rd_ndx),
    .i_reg_rd_data    (i_reg_rd_data),
    .o_reg_wr_en      (o_reg_wr_en),
    .o_reg_wr_ndx     (o_reg_wr_ndx),
    .o_reg_wr_data    (o_reg_wr_data),
    .o_mmu_en         (o_mmu_en),
    .o_dcache_en      (o_dcache_en),
    .o_icache_en      (o_icache_en),
    .o_baddr          (o_baddr),
    .o_dac            (o_dac),
    .i_fault_valid    (i_fault_valid),
    .i_fsr            (i_fsr),
    .i_far            (i_far),
    .o_cache_inv      (o_cache_inv),
    .i_cache_inv_done (i_cache_inv_done),
    .o_tlb_inv        (o_tlb_inv),
    .i_tlb_inv_done   (i_tlb_inv_done),
    .o_state          (o_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic        inject_fault = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_word(input logic l, input logic [3:0] crn,
                                          input logic [3:0] rd, input logic [3:0] cpn,
                                          input logic [3:0] crm);
    return {4'hE, 4'hE, 3'b000, l, crn, rd, cpn, 3'b000, 1'b1, crm};
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end on a falling edge.
  task automatic issue(input logic [31:0] word, input logic [5:0] ndx, input logic [31:0] cpsr);
    cp_bus.i_cp_word = word;
    cp_bus.i_cp_reg  = ndx;
    cp_bus.i_cpsr    = cpsr;
    cp_bus.i_dav     = 1'b1;
  endtask

  task automatic release_req(input string tag);
    cp_bus.i_dav = 1'b0;
    @(negedge i_clk);
    check({tag, "_rel_done"},  32'(cp_bus.o_done), 32'd0);
    check({tag, "_rel_state"}, 32'(o_state), 32'd0);
  endtask

  // MCR up to the end of RD_WAIT; data is presented only in the cycle after o_reg_en.
  task automatic mcr_front(input string tag, input logic [3:0] crn, input logic [3:0] crm,
                           input logic [5:0] ndx, input logic [31:0] data);
    issue(mk_word(1'b0, crn, 4'd1, 4'd15, crm), ndx, SVC);
    @(negedge i_clk);
    check({tag, "_reg_en"},  32'(o_reg_en), 32'd1);
    check({tag, "_rd_ndx"},  32'(o_reg_rd_ndx), 32'(ndx));
    check({tag, "_done_c1"}, 32'(cp_bus.o_done), 32'd0);
    @(posedge i_clk); #1;
    i_reg_rd_data = data;
    if (inject_fault) i_fault_valid = 1'b1;
    @(negedge i_clk);
    check({tag, "_done_c2"},   32'(cp_bus.o_done), 32'd0);
    check({tag, "_reg_en_c2"}, 32'(o_reg_en), 32'd0);
    @(posedge i_clk); #1;
    i_reg_rd_data = GARBAGE;
    i_fault_valid = 1'b0;
  endtask

  task automatic mcr(input string tag, input logic [3:0] crn, input logic [3:0] crm,
                     input logic [5:0] ndx, input logic [31:0] data);
    mcr_front(tag, crn, crm, ndx, data);
    @(negedge i_clk);
    check({tag, "_done_c3"},  32'(cp_bus.o_done), 32'd1);
    check({tag, "_undef_c3"}, 32'(cp_bus.o_undef), 32'd0);
    release_req(tag);
  endtask

  task automatic mrc(input string tag, input logic [3:0] crn, input logic [3:0] rd_f,
                     input logic [5:0] ndx, input logic [31:0] exp);
    issue(mk_word(1'b1, crn, rd_f, 4'd15, 4'd0), ndx, SVC);
    @(negedge i_clk);
    check({tag, "_wr_en"}, 32'(o_reg_wr_en), (rd_f != 4'd15) ? 32'd1 : 32'd0);
    if (rd_f != 4'd15) begin
      check({tag, "_wr_ndx"},  32'(o_reg_wr_ndx), 32'(ndx));
      check({tag, "_wr_data"}, o_reg_wr_data, exp);
    end
    check({tag, "_done_c1"}, 32'(cp_bus.o_done), 32'd0);
    @(negedge i_clk);
    check({tag, "_done_c2"},  32'(cp_bus.o_done), 32'd1);
    check({tag, "_wr_en_c2"}, 32'(o_reg_wr_en), 32'd0);
    release_req(tag);
  endtask

  // Rejected request with i_dav held four extra cycles after done.
  task automatic illegal(input string tag, input logic [31:0] word, input logic [31:0] cpsr);
    issue(word, 6'd7, cpsr);
    i_reg_rd_data = 32'hFFFF_FFFF;
    @(negedge i_clk);
    check({tag, "_done"},   32'(cp_bus.o_done), 32'd1);
    check({tag, "_undef"},  32'(cp_bus.o_undef), 32'd1);
    check({tag, "_reg_en"}, 32'(o_reg_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check({tag, "_hold_done"},  32'(cp_bus.o_done), 32'd1);
      check({tag, "_hold_undef"}, 32'(cp_bus.o_undef), 32'd0);
      check({tag, "_hold_rf"},    32'({o_reg_en, o_reg_wr_en}), 32'd0);
    end
    release_req(tag);
    i_reg_rd_data = GARBAGE;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    i_reset          = 1'b1;
    cp_bus.i_dav     = 1'b0;
    cp_bus.i_cp_word = 32'd0;
    cp_bus.i_cp_reg  = 6'd0;
    cp_bus.i_cpsr    = SVC;
    i_reg_rd_data    = GARBAGE;
    i_fault_valid    = 1'b0;
    i_fsr            = 8'd0;
    i_far            = 32'd0;
    i_cache_inv_done = 1'b0;
    i_tlb_inv_done   = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_done",  32'({cp_bus.o_done, cp_bus.o_undef}), 32'd0);
    check("rst_en",    32'({o_mmu_en, o_dcache_en, o_icache_en}), 32'd0);
    check("rst_maint", 32'({o_cache_inv, o_tlb_inv}), 32'd0);
    check("rst_dac",   o_dac, 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("idle_done", 32'(cp_bus.o_done), 32'd0);

    // Control register: all three enables, then read back.
    mcr("c1_wr", 4'd1, 4'd0, 6'd0, 32'h0000_1005);
    check("c1_en", 32'({o_mmu_en, o_dcache_en, o_icache_en}), 32'd7);
    mrc("c1_rd", 4'd1, 4'd2, 6'd9, 32'h0000_1005);
    mrc("c0_rd", 4'd0, 4'd3, 6'd3, 32'h4107_B000);

    // c1 drops unimplemented bits; only D cache stays on.
    mcr("c1_part", 4'd1, 4'd0, 6'd1, 32'hFFFF_EFFA | 32'h4);
    check("c1_part_en", 32'({o_mmu_en, o_dcache_en, o_icache_en}), 32'b010);
    mrc("c1_part_rd", 4'd1, 4'd4, 6'd2, 32'h0000_0004);

    mcr("c2_wr", 4'd2, 4'd0, 6'd4, 32'hFFFF_FFFF);
    check("c2_baddr", 32'(o_baddr), 32'h0003_FFFF);
    mrc("c2_rd", 4'd2, 4'd5, 6'd45, 32'hFFFF_C000);
    mcr("c3_wr", 4'd3, 4'd0, 6'd6, 32'h5555_AAAA);
    check("c3_dac", o_dac, 32'h5555_AAAA);
    mcr("c5_wr", 4'd5, 4'd0, 6'd8, 32'h1234_56A5);
    mrc("c5_rd", 4'd5, 4'd6, 6'd10, 32'h0000_00A5);
    mrc("rd_pc", 4'd3, 4'd15, 6'd11, 32'h0);
    mcr("c9_wr", 4'd9, 4'd0, 6'd12, 32'hFFFF_FFFF);
    mrc("c9_rd", 4'd9, 4'd7, 6'd13, 32'h0);

    // Cache invalidate both; a TLB done must not release it.
    mcr_front("c7_both", 4'd7, 4'd7, 6'd14, 32'd0);
    @(negedge i_clk);
    check("c7_req", 32'({o_cache_inv, o_tlb_inv}), 32'b110);
    check("c7_done_early", 32'(cp_bus.o_done), 32'd0);
    i_tlb_inv_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      i_tlb_inv_done = 1'b0;
      check("c7_held", 32'(o_cache_inv), 32'd3);
      check("c7_wait_done", 32'(cp_bus.o_done), 32'd0);
    end
    i_cache_inv_done = 1'b1;
    @(negedge i_clk);
    i_cache_inv_done = 1'b0;
    check("c7_drop", 32'(o_cache_inv), 32'd0);
    check("c7_done", 32'(cp_bus.o_done), 32'd1);
    release_req("c7_both");

    // D-only invalidate.
    mcr_front("c7_d", 4'd7, 4'd6, 6'd14, 32'd0);
    @(negedge i_clk);
    check("c7_d_req", 32'(o_cache_inv), 32'b01);
    i_cache_inv_done = 1'b1;
    @(negedge i_clk);
    i_cache_inv_done = 1'b0;
    check("c7_d_done", 32'({cp_bus.o_done, o_cache_inv}), 32'b100);
    release_req("c7_d");

    // CRm with no cache operation completes like a plain MCR.
    mcr("c7_nop", 4'd7, 4'd0, 6'd14, 32'd0);
    check("c7_nop_req", 32'(o_cache_inv), 32'd0);

    // TLB invalidate; a cache done must not release it.
    mcr_front("c8", 4'd8, 4'd7, 6'd15, 32'd0);
    @(negedge i_clk);
    check("c8_req", 32'({o_cache_inv, o_tlb_inv}), 32'b001);
    i_cache_inv_done = 1'b1;
    @(negedge i_clk);
    i_cache_inv_done = 1'b0;
    check("c8_held", 32'({cp_bus.o_done, o_tlb_inv}), 32'b01);
    repeat (3) @(negedge i_clk);
    i_tlb_inv_done = 1'b1;
    @(negedge i_clk);
    i_tlb_inv_done = 1'b0;
    check("c8_drop", 32'({cp_bus.o_done, o_tlb_inv}), 32'b10);
    release_req("c8");

    // Illegal requests: user mode, wrong CP#, LDC, CDP.
    illegal("usr", mk_word(1'b0, 4'd1, 4'd0, 4'd15, 4'd0), USR);
    illegal("cp14", mk_word(1'b0, 4'd1, 4'd0, 4'd14, 4'd0), SVC);
    w = mk_word(1'b0, 4'd1, 4'd0, 4'd15, 4'd0);
    w[27:24] = 4'b1100;
    illegal("ldc", w, SVC);
    w = mk_word(1'b0, 4'd1, 4'd0, 4'd15, 4'd0);
    w[4] = 1'b0;
    illegal("cdp", w, SVC);
    check("illegal_c1", 32'({o_mmu_en, o_dcache_en, o_icache_en}), 32'b010);

    // Fault arriving in the same cycle as an MCR to c6.
    i_fsr = 8'h05;
    i_far = 32'hDEAD_BEEF;
    inject_fault = 1'b1;
    mcr("c6_fault", 4'd6, 4'd0, 6'd16, 32'h0000_0000);
    inject_fault = 1'b0;
    mrc("c6_rd", 4'd6, 4'd8, 6'd17, 32'hDEAD_BEEF);
    mrc("c5_fsr", 4'd5, 4'd8, 6'd17, 32'h0000_0005);

    // Fault capture while idle.
    i_fsr = 8'h0D;
    i_far = 32'h0000_1000;
    i_fault_valid = 1'b1;
    @(negedge i_clk);
    i_fault_valid = 1'b0;
    mrc("idle_fsr", 4'd5, 4'd1, 6'd18, 32'h0000_000D);
    mrc("idle_far", 4'd6, 4'd1, 6'd18, 32'h0000_1000);

    // Reset in the middle of a maintenance wait.
    mcr_front("rst_maint", 4'd7, 4'd5, 6'd19, 32'd0);
    @(negedge i_clk);
    check("rm_req", 32'(o_cache_inv), 32'b10);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("rm_inv",   32'({o_cache_inv, o_tlb_inv}), 32'd0);
    check("rm_en",    32'({o_mmu_en, o_dcache_en, o_icache_en}), 32'd0);
    check("rm_state", 32'(o_state), 32'd0);
    check("rm_done",  32'(cp_bus.o_done), 32'd0);
    check("rm_dac",   o_dac, 32'd0);
    i_reset = 1'b0;
    cp_bus.i_dav = 1'b0;
    @(negedge i_clk);
    check("rm_idle", 32'({o_state, o_reg_en, o_reg_wr_en}), 32'd0);
    mrc("rm_c6", 4'd6, 4'd1, 6'd20, 32'h0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net against a stuck bench.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its report");
    $fatal(1);
  end

endmodule
